// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory controller.
package mips_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] WORD_OFS_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & WORD_OFS_MASK);
  endfunction

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// Data-memory req/ack bus; the controller is master, the memory is slave.
interface mem_stage_dmem_ctrl_if #(
  parameter int DATA_W = 32
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_dmem_ctrl_timeout_ctr.sv
// BUSY-cycle counter; tc goes high on the TIMEOUT_CYC-th counted cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64,
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: launches one req/ack access per load/store and
// stalls the pipeline until it retires (min 2 stall cycles, +1 per wait cycle).
module mem_stage_dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = 64,
  parameter logic [DATA_W-1:0] ERR_RDATA   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_dmem_MEM,
  input  logic                  write_dmem_MEM,
  input  logic [DATA_W-1:0]     alu_result_MEM,
  input  logic [DATA_W-1:0]     regf_rdata2_MEM,
  mem_stage_dmem_ctrl_if.master dmem,
  output logic                  stall_mem,
  output logic [DATA_W-1:0]     rdata_MEM,
  output logic                  access_done,
  output logic                  align_err,
  output logic                  timeout_err
);

  logic [1:0] state;
  logic       access;
  logic       misaligned;
  logic       launch;
  logic       in_busy;
  logic       to_en;
  logic       to_tc;

  assign access     = read_dmem_MEM | write_dmem_MEM;
  assign misaligned = is_misaligned(alu_result_MEM[1:0]);
  assign launch     = (state == ST_IDLE) & access & ~misaligned;
  assign in_busy    = (state == ST_BUSY);

  // Stall is raised combinationally on detect so EX/MEM holds the instruction
  // through BUSY; DONE releases it while the same instruction is still present.
  assign stall_mem = launch | in_busy;
  assign align_err = (state == ST_IDLE) & access & misaligned;
  assign to_en     = in_busy & ~dmem.dmem_ack & ~to_tc;

  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk(clk),
    .rst(rst),
    .clr(launch),
    .en (to_en),
    .tc (to_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      rdata_MEM       <= '0;
      access_done     <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      access_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= write_dmem_MEM;
            dmem.dmem_addr  <= {alu_result_MEM[DATA_W-1:2], 2'b00};
            dmem.dmem_wdata <= regf_rdata2_MEM;
            state           <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            if (!dmem.dmem_we) rdata_MEM <= dmem.dmem_rdata;
            access_done   <= 1'b1;
            state         <= ST_DONE;
          end else if (to_tc) begin
            dmem.dmem_req <= 1'b0;
            timeout_err   <= 1'b1;
            if (!dmem.dmem_we) rdata_MEM <= ERR_RDATA;
            access_done   <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
